// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester arbiter (CPU and loader/debug port) in front of a single
//   synchronous single-port RAM. Each transaction takes three cycles:
//   IDLE (request sampled, winner latched), ACCESS (RAM strobe for exactly
//   one cycle), RESP (one-cycle ack to the owner, read data returned).
//
//   Configuration macro: MEM_ARBITER_ROUND_ROBIN_EN
//     defined   : ties go to the requester not granted last
//                 (CPU wins the first tie after reset)
//     undefined : fixed priority, CPU always wins ties
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-low
//   cpu_req/we    in   CPU request / write enable
//   cpu_addr      in   9-bit word address
//   cpu_wdata     in   32-bit write data
//   cpu_rdata     out  32-bit read data (valid from the ack cycle on)
//   cpu_ack       out  one-cycle completion pulse
//   ldr_*         -    same set for the loader/debug port
//   ram_en/we     out  RAM strobe / write enable, high only in ACCESS
//   ram_addr      out  RAM word address (holds last driven value)
//   ram_wdata     out  RAM write data (holds last driven value)
//   ram_rdata     in   RAM read data, valid the cycle after ram_en
//   grant         out  current owner: 00 none, 01 CPU, 10 loader
//   access_count  out  completed transactions, saturating at 16'hFFFF

module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [8:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [8:0]  ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic [31:0] ldr_rdata,
  output logic        ldr_ack,
  output logic        ram_en,
  output logic        ram_we,
  output logic [8:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [1:0]  grant,
  output logic [15:0] access_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_LDR  = 2'b10;

  state_t      state;
  state_t      next_state;
  logic        pick_cpu;
  logic        pick_ldr;
  logic        txn_we;
  logic [31:0] cpu_rdata_q;
  logic [31:0] ldr_rdata_q;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // 1 = loader was granted last; reset value makes the CPU win the first tie
  logic        last_ldr;
`endif

  // Arbitration among requests seen in IDLE
  always_comb begin
    pick_cpu = 1'b0;
    pick_ldr = 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    if (cpu_req && ldr_req) begin
      if (last_ldr) begin
        pick_cpu = 1'b1;
      end else begin
        pick_ldr = 1'b1;
      end
    end else begin
      pick_cpu = cpu_req;
      pick_ldr = ldr_req;
    end
`else
    pick_cpu = cpu_req;
    pick_ldr = ldr_req && !cpu_req;
`endif
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_cpu || pick_ldr) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath and registered outputs. The RAM strobe is registered on the
  // IDLE->ACCESS edge so it is high for exactly the ACCESS cycle; the ack is
  // registered on the ACCESS->RESP edge so it is high for exactly RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant        <= GRANT_NONE;
      cpu_ack      <= 1'b0;
      ldr_ack      <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      access_count <= '0;
      txn_we       <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_ldr     <= 1'b1;
`endif
    end else begin
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      ram_en  <= 1'b0;
      ram_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_cpu) begin
            grant     <= GRANT_CPU;
            txn_we    <= cpu_we;
            ram_en    <= 1'b1;
            ram_we    <= cpu_we;
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
          end else if (pick_ldr) begin
            grant     <= GRANT_LDR;
            txn_we    <= ldr_we;
            ram_en    <= 1'b1;
            ram_we    <= ldr_we;
            ram_addr  <= ldr_addr;
            ram_wdata <= ldr_wdata;
          end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
          if (pick_cpu || pick_ldr) begin
            last_ldr <= pick_ldr;
          end
`endif
        end
        ACCESS: begin
          cpu_ack <= (grant == GRANT_CPU);
          ldr_ack <= (grant == GRANT_LDR);
          if (access_count != '1) begin
            access_count <= access_count + 16'd1;
          end
        end
        RESP: begin
          if (!txn_we) begin
            if (grant == GRANT_CPU) begin
              cpu_rdata_q <= ram_rdata;
            end else if (grant == GRANT_LDR) begin
              ldr_rdata_q <= ram_rdata;
            end
          end
          grant <= GRANT_NONE;
        end
        default: ;
      endcase
    end
  end

  // RAM read data only arrives in RESP; it is forwarded straight to the
  // owner so the data is valid alongside the ack, then held in the register.
  always_comb begin
    cpu_rdata = cpu_rdata_q;
    ldr_rdata = ldr_rdata_q;
    if (state == RESP && !txn_we) begin
      if (grant == GRANT_CPU) begin
        cpu_rdata = ram_rdata;
      end else if (grant == GRANT_LDR) begin
        ldr_rdata = ram_rdata;
      end
    end
  end

endmodule
